lsb_serializer: RTL and testbench

- Parallel-in, serial-out stage that feeds the bit-serial two's-complement FSM directly upstream.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per clock.
- Drives a one-cycle clear to the downstream FSM before each word, so every word is complemented from a fresh state.
- Also flags the last bit of each word so the downstream collector can frame the result.

---
 rtl/lsb_serializer_if.sv | 31 +++
 rtl/lsb_serializer.sv | 105 ++++++++++
 tb/tb_lsb_serializer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lsb_serializer_if.sv
// ============================================================================
// Module   : lsb_serializer_if
// Brief    : Word-in / bit-out handshake bundle for lsb_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsb_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             last_bit;
    logic             ds_clr;

    // master: word source plus serial sink; slave: the serializer itself
    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, last_bit, ds_clr
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, last_bit, ds_clr
    );
endinterface

`default_nettype wire

// File: rtl/lsb_serializer.sv
// ============================================================================
// Module   : lsb_serializer
// Brief    : Parallel-in, LSB-first serial-out stage with downstream clear and
//            last-bit framing for a bit-serial two's-complement FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_serializer #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           res,
    lsb_serializer_if.slave     bus
);

    localparam int                  c_CNT_W  = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST   = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0]          c_IDLE   = 2'd0;
    localparam logic [1:0]          c_CLR    = 2'd1;
    localparam logic [1:0]          c_SHIFT  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_at_last;
    logic               w_ready;
    logic               w_accept;

    // Readiness depends only on registered state, so the handshake never
    // creates a combinational path from din_valid to din_ready.
    assign w_at_last = (r_state == c_SHIFT) && (r_cnt == c_LAST);
    assign w_ready   = (r_state == c_IDLE) || w_at_last;
    assign w_accept  = w_ready && bus.din_valid;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.din_valid) begin
                    w_state_nxt = c_CLR;
                end
            end
            c_CLR: begin
                w_state_nxt = c_SHIFT;
            end
            c_SHIFT: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = bus.din_valid ? c_CLR : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Datapath: load on an accepted handshake, otherwise shift while in SHIFT.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_shreg <= bus.din;
            end else if (r_state == c_SHIFT) begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end

            if ((r_state != c_SHIFT) || w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.din_ready  = w_ready;
        bus.ds_clr     = 1'b1;
        bus.sout_valid = 1'b0;
        bus.sout       = 1'b0;
        bus.last_bit   = 1'b0;
        if (r_state == c_SHIFT) begin
            bus.ds_clr     = 1'b0;
            bus.sout_valid = 1'b1;
            bus.sout       = r_shreg[0];
            bus.last_bit   = w_at_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsb_serializer.sv
// ============================================================================
// Module   : tb_lsb_serializer
// Brief    : Self-checking bench for lsb_serializer (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsb_serializer;

    localparam int W = 8;

    logic clk;
    logic res;

    lsb_serializer_if #(.WIDTH(W)) bus();

    lsb_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time elapsed since the accepting edge.
    // t=1 is the clear cycle, t=2..W+1 carry word bit t-2.
    bit             m_busy = 1'b0;
    int             m_t    = 0;
    logic [W-1:0]   m_word = '0;

    // Packed observation order: {din_ready, ds_clr, sout_valid, last_bit, sout}
    function automatic logic [4:0] model_out();
        int  k;
        bit  lst;
        if (!m_busy)   return 5'b11000;
        if (m_t == 1)  return 5'b01000;
        k   = m_t - 2;
        lst = (k == W - 1);
        return {lst, 1'b0, 1'b1, lst, m_word[k]};
    endfunction

    function automatic void model_update(input bit r, input bit v, input logic [W-1:0] d);
        logic [4:0] pre;
        pre = model_out();
        if (!r) begin
            m_busy = 1'b0;
        end else if (pre[4] && v) begin
            m_busy = 1'b1;
            m_t    = 1;
            m_word = d;
        end else if (m_busy) begin
            if (m_t == W + 1) m_busy = 1'b0;
            else              m_t++;
        end
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {rdy,clr,vld,last,sout}=%b expected %b", name, got, exp);
        end
    endtask

    logic [4:0] got;

    task automatic step(input bit r, input bit v, input logic [W-1:0] d, input string name);
        @(negedge clk);
        res           = r;
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        model_update(r, v, d);
        #1;
        got = {bus.din_ready, bus.ds_clr, bus.sout_valid, bus.last_bit, bus.sout};
        check(name, got, model_out());
    endtask

    // Downstream complementer stand-in: its clear is ds_clr, and it inverts
    // every bit after the first 1 it has seen in the word.
    bit             e2e_en = 1'b0;
    bit             ds_seen = 1'b0;
    int             ds_idx = 0;
    logic [W-1:0]   ds_acc = '0;
    logic [W-1:0]   e2e_q[$];

    always @(posedge clk) begin
        if (bus.ds_clr) begin
            ds_seen = 1'b0;
            ds_idx  = 0;
        end else if (bus.sout_valid) begin
            ds_acc[ds_idx] = bus.sout ^ ds_seen;
            ds_seen        = ds_seen | bus.sout;
            ds_idx++;
            if (bus.last_bit && e2e_en) e2e_q.push_back(ds_acc);
        end
    end

    typedef struct {
        bit           r;
        bit           v;
        logic [W-1:0] d;
        logic [4:0]   exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit v, input logic [W-1:0] d, input logic [4:0] e);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.exp = e;
        tbl.push_back(x);
    endfunction

    function automatic void add_word_bits(input logic [W-1:0] w, input bit v, input logic [W-1:0] d);
        for (int k = 0; k < W; k++) begin
            if (k == W - 1) add(1'b1, v, d, {1'b1, 1'b0, 1'b1, 1'b1, w[k]});
            else            add(1'b1, v, d, {1'b0, 1'b0, 1'b1, 1'b0, w[k]});
        end
    endfunction

    logic [W-1:0] e2e_in  [4];
    logic [W-1:0] e2e_exp [4];

    initial begin
        res           = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;

        // Reset, idle, single word 0x2C, then 0x2C/0x81 back-to-back
        add(1'b0, 1'b0, 8'h00, 5'b11000);
        add(1'b0, 1'b1, 8'h55, 5'b11000);
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 8'h00, 5'b11000);
        add(1'b1, 1'b1, 8'h2C, 5'b01000);
        add_word_bits(8'h2C, 1'b0, 8'h00);
        add(1'b1, 1'b0, 8'h00, 5'b11000);
        add(1'b1, 1'b1, 8'h2C, 5'b01000);
        add_word_bits(8'h2C, 1'b1, 8'h81);
        add(1'b1, 1'b1, 8'h81, 5'b01000);
        add_word_bits(8'h81, 1'b0, 8'h00);
        add(1'b1, 1'b0, 8'h00, 5'b11000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, $sformatf("model_tbl[%0d]", i));
            check($sformatf("tbl[%0d]", i), got, tbl[i].exp);
        end

        // Stall: 0xFF offered from cnt=3 onwards, taken only on the last-bit edge
        step(1'b1, 1'b1, 8'h2C, "stall_acc");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, "stall_pre");
        step(1'b1, 1'b1, 8'hFF, "stall_e5");
        check("stall_hold", got, 5'b00100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF, "stall_wait");
        check("stall_lastbit", got, 5'b10110);
        step(1'b1, 1'b1, 8'hFF, "stall_e9");
        check("stall_clr", got, 5'b01000);
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 8'h00, "stall_ff_bits");
        check("stall_ff_last", got, 5'b10111);
        step(1'b1, 1'b0, 8'h00, "stall_idle");

        // Reset mid-word at the edge where cnt=4, then word 0x01
        step(1'b1, 1'b1, 8'hA5, "mid_acc");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, "mid_bits");
        step(1'b0, 1'b1, 8'h3C, "mid_rst");
        check("mid_rst_state", got, 5'b11000);
        step(1'b1, 1'b1, 8'h01, "mid_acc01");
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 8'h00, "mid_01_bits");
        step(1'b1, 1'b0, 8'h00, "mid_idle");

        // End-to-end through the complementer
        e2e_in[0] = 8'h2C; e2e_in[1] = 8'h01; e2e_in[2] = 8'h80; e2e_in[3] = 8'h00;
        e2e_exp[0] = 8'hD4; e2e_exp[1] = 8'hFF; e2e_exp[2] = 8'h80; e2e_exp[3] = 8'h00;
        e2e_en = 1'b1;
        step(1'b1, 1'b1, e2e_in[0], "e2e_acc");
        for (int w = 1; w < 4; w++)
            for (int i = 0; i < W + 1; i++) step(1'b1, 1'b1, e2e_in[w], "e2e_run");
        for (int i = 0; i < W + 1; i++) step(1'b1, 1'b0, 8'h00, "e2e_tail");
        for (int i = 0; i < 20 && e2e_q.size() < 4; i++) step(1'b1, 1'b0, 8'h00, "e2e_wait");
        e2e_en = 1'b0;
        checks++;
        if (e2e_q.size() != 4) begin
            errors++;
            $display("FAIL e2e_count: got %0d words expected 4", e2e_q.size());
        end else begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (e2e_q[w] !== e2e_exp[w]) begin
                    errors++;
                    $display("FAIL e2e_word[%0d]: got %h expected %h", w, e2e_q[w], e2e_exp[w]);
                end
            end
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                 W'($urandom), $sformatf("rand[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
